sub_row_collect: RTL

SUB_ROW_COLLECT -- requirements
Module: sub_row_collect

---
 rtl/sub_row_collect.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/sub_row_collect.sv
// Collects serial elements into full-width rows, tagging each row with its step index.
// A one-deep pending slot backs up the output register so a closing beat never stalls.
module sub_row_collect #(
  parameter int unsigned ELEMENT_NUM   = 32,
  parameter int unsigned ELEMENT_WIDTH = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        in_vld,
  input  logic [ELEMENT_WIDTH-1:0]                    in_data,
  input  logic                                        in_last,
  output logic                                        in_rdy,
  output logic                                        out_vld,
  output logic [ELEMENT_NUM-1:0][ELEMENT_WIDTH-1:0]   out_row,
  input  logic                                        out_rdy,
  output logic [7:0]                                  step_num,
  output logic                                        err_short
);

  localparam int unsigned CNT_W    = (ELEMENT_NUM > 1) ? $clog2(ELEMENT_NUM) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ELEMENT_NUM - 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                                      state;
  state_t                                      state_nxt;

  logic [ELEMENT_NUM-1:0][ELEMENT_WIDTH-1:0]   asm_row;
  logic [ELEMENT_NUM-1:0][ELEMENT_WIDTH-1:0]   closed_row_c;
  logic [ELEMENT_NUM-1:0][ELEMENT_WIDTH-1:0]   pend_row;
  logic [7:0]                                  pend_step;
  logic [7:0]                                  step_cnt;
  logic [CNT_W-1:0]                            elem_cnt;

  logic beat_c;
  logic at_end_c;
  logic close_c;
  logic out_free_c;
  logic load_out_c;
  logic load_pend_c;
  logic drain_c;
  logic drop_c;

  assign beat_c     = in_vld & in_rdy;
  assign at_end_c   = (elem_cnt == LAST_IDX);
  assign close_c    = beat_c & (at_end_c | in_last);
  assign out_free_c = ~out_vld | out_rdy;

  // Row as it leaves assembly: current beat inserted, slots past it zeroed on early close.
  always_comb begin
    closed_row_c = '0;
    for (int k = 0; k < int'(ELEMENT_NUM); k++) begin
      if (CNT_W'(k) < elem_cnt) begin
        closed_row_c[k] = asm_row[k];
      end else if (CNT_W'(k) == elem_cnt) begin
        closed_row_c[k] = in_data;
      end else begin
        closed_row_c[k] = '0;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL: begin
        if (close_c && !out_free_c) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_vld && out_rdy) begin
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // Datapath controls decoded from state.
  always_comb begin
    load_out_c  = 1'b0;
    load_pend_c = 1'b0;
    drain_c     = 1'b0;
    drop_c      = 1'b0;
    case (state)
      FILL: begin
        load_out_c  = close_c & out_free_c;
        load_pend_c = close_c & ~out_free_c;
        drop_c      = ~close_c & out_vld & out_rdy;
      end
      HOLD: begin
        drain_c = out_vld & out_rdy;
      end
      default: begin
        drop_c = 1'b0;
      end
    endcase
  end

  // Assembly buffer, element index and step counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_row  <= '0;
      elem_cnt <= '0;
      step_cnt <= '0;
    end else if (beat_c) begin
      asm_row[elem_cnt] <= in_data;
      elem_cnt          <= close_c ? '0 : elem_cnt + CNT_W'(1);
      if (close_c && in_last) begin
        step_cnt <= step_cnt + 8'd1;
      end
    end
  end

  // Pending slot used only while the output register is still occupied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_row  <= '0;
      pend_step <= '0;
    end else if (load_pend_c) begin
      pend_row  <= closed_row_c;
      pend_step <= step_cnt;
    end
  end

  // Output register and handshake flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld   <= 1'b0;
      out_row   <= '0;
      step_num  <= '0;
      err_short <= 1'b0;
      in_rdy    <= 1'b1;
    end else begin
      err_short <= close_c & ~at_end_c;
      in_rdy    <= (state_nxt == FILL);
      if (load_out_c) begin
        out_vld  <= 1'b1;
        out_row  <= closed_row_c;
        step_num <= step_cnt;
      end else if (drain_c) begin
        out_vld  <= 1'b1;
        out_row  <= pend_row;
        step_num <= pend_step;
      end else if (drop_c) begin
        out_vld  <= 1'b0;
      end
    end
  end

endmodule
